decode_scoreboard: RTL and testbench
====================================

# decode_scoreboard

Register-hazard scoreboard and issue controller for the 32-bit decode stage. It tracks destination registers of instructions issued from decode but not yet written back to the register file. It stalls decode on read-after-write hazards, on per-register or global in-flight limits, and while draining after a pipeline flush. It sits beside the decode unit: it consumes decode's rs1/rs2/rd fields and the writeback `write`/`write_reg` pair, and produces the stage's ready/stall signal.

## Interface
- `CORE`, 0, core index printed in scan output
- `MAX_INFLIGHT`, 4, global limit on issued-but-unretired register writes (1..7)
- `SCAN_CYCLES_MIN`, 0, first cycle of scan printing
- `SCAN_CYCLES_MAX`, 1000, last cycle of scan printing
- `clock`  input  1  single clock; all state updates on its rising edge
- `reset`  input  1  synchronous, active-high
- `decode_valid`  input  1  decode holds an instruction wanting to issue
- `rs1`  input  5  source register 1 (instruction[19:15])
- `rs2`  input  5  source register 2 (instruction[24:20])
- `rd`  input  5  destination register (instruction[11:7])
- `uses_rs1`  input  1  instruction reads rs1
- `uses_rs2`  input  1  instruction reads rs2
- `writes_rd`  input  1  instruction writes rd
- `write`  input  1  writeback retires a register write this cycle
- `write_reg`  input  5  register being retired
- `flush`  input  1  discard younger instructions; begin drain
- `decode_ready`  output  1  issue permitted; issue = decode_valid & decode_ready
- `stall`  output  1  decode_valid & ~decode_ready
- `rs1_pending`  output  1  rs1 hazard (uses_rs1, rs1≠0, count[rs1]≠0)
- `rs2_pending`  output  1  rs2 hazard, same rule
- `inflight_count`  output  3  total outstanding writes
- `underflow_err`  output  1  sticky: retire with zero count
- `scan`  input  1  enables $display trace

## Operation
- State: 32 × 2-bit pending counters (x0 never tracked, always reads 0), 3-bit global `inflight_count`, 2-state FSM {RUN, DRAIN}, sticky error bit, 32-bit cycle counter.
- RUN, `decode_ready` = 1 only when all of the following hold:
  - ~rs1_pending and ~rs2_pending.
  - If writes_rd & rd≠0: count[rd]≠3.
  - inflight_count < MAX_INFLIGHT.
- `decode_ready` is combinational from registered state and current rs/rd/uses fields only. A same-cycle retire does not clear a hazard; there is no bypass.
- Issue (RUN, issue=1, writes_rd, rd≠0): count[rd]+1, inflight+1.
- Retire (`write`, write_reg≠0):
  - If count[write_reg]≠0: count[write_reg]−1, inflight−1.
  - Otherwise: counters unchanged, underflow_err←1.
  - Retire of x0 is ignored.
- Issue and retire in the same cycle:
  - Same register: count unchanged, inflight unchanged.
  - Different registers: each applied independently; inflight net unchanged.
- `flush` (any state, not reset): FSM→DRAIN next cycle. Any issue in the flush cycle is suppressed, and `decode_ready` is forced 0 that cycle.
- DRAIN:
  - decode_ready=0.
  - Retires are still counted.
  - When inflight_count==0, FSM→RUN the following cycle.
  - If flush asserts while already in DRAIN, the FSM stays in DRAIN.
- underflow_err clears only on reset.
- Scan: when `scan` and SCAN_CYCLES_MIN ≤ cycle ≤ SCAN_CYCLES_MAX, $display core, cycle, FSM state, rs1/rs2/rd, pending flags, inflight_count, decode_ready.

## Timing
- Reset (synchronous, sampled on clock edge):
  - All counters 0, inflight_count 0, FSM RUN, underflow_err 0, cycle counter 0.
  - decode_ready and stall forced 0 during the reset cycle.
  - rs1_pending and rs2_pending read 0 after reset.
- Reset mid-DRAIN or mid-operation: all state clears; outstanding writes are forgotten, and later retires of them set underflow_err.
- Issue-to-hazard latency: an instruction issued at edge N makes rd pending from cycle N+1.
- Retire-to-release latency: a retire at edge N clears the hazard from cycle N+1, so a dependent instruction issues at edge N+1 at the earliest.
- flush at cycle N: issue blocked at edge N; DRAIN from N+1; RUN one cycle after inflight reaches 0.
- Saturation:
  - count[rd]==3 blocks issue to that rd.
  - inflight_count==MAX_INFLIGHT blocks all issue, including writes_rd=0 instructions (conservative; keeps logic simple).
- No counter wraps; overflow is prevented by the ready rules.

## Test plan
- After reset: issue rd=5 (writes_rd=1) → count[5]=1, inflight=1. Next instruction uses rs1=5 → rs1_pending=1, stall=1. write=1, write_reg=5 at edge N → decode_ready=1 at N+1.
- Issue rd=0 and use rs2=0 → never pending, inflight stays 0. Retire x0 → no change, underflow_err=0.
- Issue rd=7 four times with no sources → count[7] saturates at 3 and the fourth is stalled. With MAX_INFLIGHT=2, the third issue to any rd stalls.
- Simultaneous issue rd=9 and retire write_reg=9 with count[9]=1 → count[9]=1, inflight unchanged. Simultaneous issue rd=3 and retire reg 4 → count[3]+1, count[4]−1.
- inflight=2, assert flush → ready=0 for the flush cycle and DRAIN. Two retires → inflight=0, then RUN, then ready=1 one cycle later.
- Retire reg 12 with count 0 → underflow_err=1 and stays 1. Assert reset mid-DRAIN with inflight=3 → all outputs return to reset values on the next edge.

Source files
------------

// File: rtl/decode_scoreboard.sv
// Register-hazard scoreboard and issue controller for the decode stage.
// Tracks per-register outstanding writes, stalls decode on RAW hazards,
// per-register saturation and a global in-flight limit, and drains the
// pipeline after a flush before allowing issue again.
module decode_scoreboard #(
    parameter int CORE            = 0,
    parameter int MAX_INFLIGHT    = 4,
    parameter int SCAN_CYCLES_MIN = 0,
    parameter int SCAN_CYCLES_MAX = 1000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       decode_valid,
    input  logic [4:0] rs1,
    input  logic [4:0] rs2,
    input  logic [4:0] rd,
    input  logic       uses_rs1,
    input  logic       uses_rs2,
    input  logic       writes_rd,
    input  logic       write,
    input  logic [4:0] write_reg,
    input  logic       flush,
    output logic       decode_ready,
    output logic       stall,
    output logic       rs1_pending,
    output logic       rs2_pending,
    output logic [2:0] inflight_count,
    output logic       underflow_err,
    input  logic       scan
);

    typedef enum logic {
        RUN   = 1'b0,
        DRAIN = 1'b1
    } state_t;

    localparam logic [2:0] MAX_INF = 3'(MAX_INFLIGHT);

    state_t      state_reg, state_next;
    logic [1:0]  count_reg  [32];
    logic [1:0]  count_next [32];
    logic [2:0]  inflight_reg, inflight_next;
    logic        underflow_reg, underflow_next;
    logic [31:0] cycle_reg;

    logic rd_full;
    logic limit_hit;
    logic issue_wr;
    logic retire_any;
    logic retire_ok;
    logic retire_bad;

    // Hazard detection and issue permission from registered state only;
    // a retire in the same cycle does not release a hazard (no bypass).
    always_comb begin
        rs1_pending  = uses_rs1 && (rs1 != 5'd0) && (count_reg[rs1] != 2'd0);
        rs2_pending  = uses_rs2 && (rs2 != 5'd0) && (count_reg[rs2] != 2'd0);
        rd_full      = writes_rd && (rd != 5'd0) && (count_reg[rd] == 2'd3);
        limit_hit    = (inflight_reg >= MAX_INF);
        decode_ready = (state_reg == RUN) && !reset && !flush && !rs1_pending
                       && !rs2_pending && !rd_full && !limit_hit;
        stall        = decode_valid && !decode_ready && !reset;
        issue_wr     = decode_valid && decode_ready && writes_rd && (rd != 5'd0);
        retire_any   = write && (write_reg != 5'd0);
        retire_ok    = retire_any && (count_reg[write_reg] != 2'd0);
        retire_bad   = retire_any && (count_reg[write_reg] == 2'd0);
    end

    // Per-register counter update: issue and retire to the same register cancel.
    generate
        for (genvar gi = 0; gi < 32; gi++) begin : g_count
            if (gi == 0) begin : g_zero
                assign count_next[gi] = 2'd0;
            end else begin : g_reg
                logic inc;
                logic dec;
                assign inc = issue_wr && (rd == 5'(gi));
                assign dec = retire_ok && (write_reg == 5'(gi));
                // Increment on issue, decrement on valid retire, hold otherwise.
                always_comb begin
                    count_next[gi] = count_reg[gi];
                    if (inc && !dec) begin
                        count_next[gi] = count_reg[gi] + 2'd1;
                    end else if (dec && !inc) begin
                        count_next[gi] = count_reg[gi] - 2'd1;
                    end
                end
            end
        end
    endgenerate

    // Global in-flight total and sticky underflow flag.
    always_comb begin
        inflight_next  = inflight_reg;
        underflow_next = underflow_reg || retire_bad;
        if (issue_wr && !retire_ok) begin
            inflight_next = inflight_reg + 3'd1;
        end else if (retire_ok && !issue_wr) begin
            inflight_next = inflight_reg - 3'd1;
        end
    end

    // RUN/DRAIN control: flush enters DRAIN, empty pipeline returns to RUN.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            RUN: begin
                if (flush) begin
                    state_next = DRAIN;
                end
            end
            DRAIN: begin
                if (!flush && (inflight_reg == 3'd0)) begin
                    state_next = RUN;
                end
            end
            default: state_next = RUN;
        endcase
    end

    // State registers with synchronous reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < 32; i++) begin
                count_reg[i] <= 2'd0;
            end
            inflight_reg  <= 3'd0;
            underflow_reg <= 1'b0;
            state_reg     <= RUN;
            cycle_reg     <= 32'd0;
        end else begin
            for (int i = 0; i < 32; i++) begin
                count_reg[i] <= count_next[i];
            end
            inflight_reg  <= inflight_next;
            underflow_reg <= underflow_next;
            state_reg     <= state_next;
            cycle_reg     <= cycle_reg + 32'd1;
        end
    end

    assign inflight_count = inflight_reg;
    assign underflow_err  = underflow_reg;

`ifndef SYNTHESIS
    longint scan_cycle;
    assign scan_cycle = longint'({32'd0, cycle_reg});

    // Simulation-only trace of the issue state, bounded to a cycle window.
    always @(posedge clock) begin
        if (scan && !reset && (scan_cycle >= longint'(SCAN_CYCLES_MIN))
                && (scan_cycle <= longint'(SCAN_CYCLES_MAX))) begin
            $display("scan core %0d cycle %0d state %s rs1 %0d rs2 %0d rd %0d p1 %0b p2 %0b inflight %0d ready %0b",
                     CORE, cycle_reg, (state_reg == DRAIN) ? "DRAIN" : "RUN",
                     rs1, rs2, rd, rs1_pending, rs2_pending, inflight_reg, decode_ready);
        end
    end
`endif

endmodule

// File: tb/tb_decode_scoreboard.sv
// Self-checking bench for decode_scoreboard: hazards, x0, saturation,
// global limit, same-cycle issue/retire, flush/drain, underflow and reset.
module tb_decode_scoreboard;

    logic       clock = 1'b0;
    logic       reset;
    logic       decode_valid;
    logic [4:0] rs1, rs2, rd, write_reg;
    logic       uses_rs1, uses_rs2, writes_rd, write, flush, scan;

    logic       decode_ready, stall, rs1_pending, rs2_pending, underflow_err;
    logic [2:0] inflight_count;
    logic       ready2, stall2, p1_2, p2_2, err2;
    logic [2:0] infl2;

    int checks = 0;
    int errors = 0;
    int exp_q[$];

    always #5 clock = ~clock;

    decode_scoreboard #(.CORE(0), .MAX_INFLIGHT(4)) dut (
        .clock(clock), .reset(reset), .decode_valid(decode_valid),
        .rs1(rs1), .rs2(rs2), .rd(rd), .uses_rs1(uses_rs1), .uses_rs2(uses_rs2),
        .writes_rd(writes_rd), .write(write), .write_reg(write_reg), .flush(flush),
        .decode_ready(decode_ready), .stall(stall), .rs1_pending(rs1_pending),
        .rs2_pending(rs2_pending), .inflight_count(inflight_count),
        .underflow_err(underflow_err), .scan(scan)
    );

    decode_scoreboard #(.CORE(1), .MAX_INFLIGHT(2)) dut2 (
        .clock(clock), .reset(reset), .decode_valid(decode_valid),
        .rs1(rs1), .rs2(rs2), .rd(rd), .uses_rs1(uses_rs1), .uses_rs2(uses_rs2),
        .writes_rd(writes_rd), .write(write), .write_reg(write_reg), .flush(flush),
        .decode_ready(ready2), .stall(stall2), .rs1_pending(p1_2),
        .rs2_pending(p2_2), .inflight_count(infl2),
        .underflow_err(err2), .scan(scan)
    );

    task automatic idle();
        decode_valid = 0; rs1 = 0; rs2 = 0; rd = 0;
        uses_rs1 = 0; uses_rs2 = 0; writes_rd = 0;
        write = 0; write_reg = 0; flush = 0;
    endtask

    task automatic instr(input logic v, input logic [4:0] a, input logic [4:0] b,
                         input logic [4:0] d, input logic u1, input logic u2, input logic w);
        decode_valid = v; rs1 = a; rs2 = b; rd = d;
        uses_rs1 = u1; uses_rs2 = u2; writes_rd = w;
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        idle();
        reset = 1;
        tick();
        reset = 0;
        exp_q.delete();
    endtask

    task automatic test_reset();
        idle();
        reset = 1;
        instr(1, 1, 2, 3, 0, 0, 1);
        #1;
        checks++;
        if (decode_ready !== 1'b0) begin errors++; $display("FAIL reset_ready: got %0b expected 0", decode_ready); end
        checks++;
        if (stall !== 1'b0) begin errors++; $display("FAIL reset_stall: got %0b expected 0", stall); end
        tick();
        reset = 0;
        instr(1, 1, 2, 3, 1, 1, 1);
        #1;
        checks++;
        if (inflight_count !== 3'd0) begin errors++; $display("FAIL reset_inflight: got %0d expected 0", inflight_count); end
        checks++;
        if (underflow_err !== 1'b0) begin errors++; $display("FAIL reset_err: got %0b expected 0", underflow_err); end
        checks++;
        if (rs1_pending !== 1'b0 || rs2_pending !== 1'b0) begin
            errors++; $display("FAIL reset_pending: got %0b%0b expected 00", rs1_pending, rs2_pending);
        end
        checks++;
        if (decode_ready !== 1'b1) begin errors++; $display("FAIL reset_run_ready: got %0b expected 1", decode_ready); end
        idle();
        $display("txn reset: inflight %0d ready %0b", inflight_count, decode_ready);
    endtask

    task automatic test_raw_hazard();
        int e;
        do_reset();
        instr(1, 0, 0, 5, 0, 0, 1);
        #1;
        checks++;
        if (decode_ready !== 1'b1) begin errors++; $display("FAIL raw_issue_ready: got %0b expected 1", decode_ready); end
        exp_q.push_back(1);
        tick();
        e = exp_q.pop_front(); checks++;
        if (inflight_count !== 3'(e)) begin errors++; $display("FAIL raw_issue_sb: inflight %0d expected %0d", inflight_count, e); end
        else $display("txn raw issue rd5: inflight %0d", inflight_count);
        instr(1, 5, 0, 6, 1, 0, 1);
        write = 1; write_reg = 5;
        #1;
        checks++;
        if (rs1_pending !== 1'b1) begin errors++; $display("FAIL raw_pending: got %0b expected 1", rs1_pending); end
        checks++;
        if (stall !== 1'b1) begin errors++; $display("FAIL raw_no_bypass_stall: got %0b expected 1", stall); end
        exp_q.push_back(0);
        tick();
        write = 0;
        #1;
        e = exp_q.pop_front(); checks++;
        if (inflight_count !== 3'(e)) begin errors++; $display("FAIL raw_retire_sb: inflight %0d expected %0d", inflight_count, e); end
        else $display("txn raw retire rd5: inflight %0d", inflight_count);
        checks++;
        if (decode_ready !== 1'b1 || rs1_pending !== 1'b0) begin
            errors++; $display("FAIL raw_release: ready %0b pending %0b expected 1 0", decode_ready, rs1_pending);
        end
        idle();
    endtask

    task automatic test_x0();
        int e;
        do_reset();
        instr(1, 0, 0, 0, 0, 1, 1);
        #1;
        checks++;
        if (rs2_pending !== 1'b0 || decode_ready !== 1'b1) begin
            errors++; $display("FAIL x0_issue: pending %0b ready %0b expected 0 1", rs2_pending, decode_ready);
        end
        exp_q.push_back(0);
        tick();
        e = exp_q.pop_front(); checks++;
        if (inflight_count !== 3'(e)) begin errors++; $display("FAIL x0_issue_sb: inflight %0d expected %0d", inflight_count, e); end
        else $display("txn x0 issue: inflight %0d", inflight_count);
        idle();
        write = 1; write_reg = 0;
        tick();
        write = 0;
        checks++;
        if (underflow_err !== 1'b0 || inflight_count !== 3'd0) begin
            errors++; $display("FAIL x0_retire: err %0b inflight %0d expected 0 0", underflow_err, inflight_count);
        end
        $display("txn x0 retire: err %0b", underflow_err);
    endtask

    task automatic test_saturation();
        int e;
        do_reset();
        for (int i = 0; i < 3; i++) begin
            instr(1, 0, 0, 7, 0, 0, 1);
            #1;
            checks++;
            if (decode_ready !== 1'b1) begin errors++; $display("FAIL sat_ready_%0d: got %0b expected 1", i, decode_ready); end
            exp_q.push_back(i + 1);
            tick();
            e = exp_q.pop_front(); checks++;
            if (inflight_count !== 3'(e)) begin errors++; $display("FAIL sat_sb_%0d: inflight %0d expected %0d", i, inflight_count, e); end
            else $display("txn sat issue rd7: inflight %0d", inflight_count);
        end
        #1;
        checks++;
        if (decode_ready !== 1'b0 || stall !== 1'b1) begin
            errors++; $display("FAIL sat_block: ready %0b stall %0b expected 0 1", decode_ready, stall);
        end
        exp_q.push_back(3);
        tick();
        e = exp_q.pop_front(); checks++;
        if (inflight_count !== 3'(e)) begin errors++; $display("FAIL sat_hold_sb: inflight %0d expected %0d", inflight_count, e); end
        else $display("txn sat stalled: inflight %0d", inflight_count);
        idle();
    endtask

    task automatic test_max_inflight();
        do_reset();
        instr(1, 0, 0, 1, 0, 0, 1);
        tick();
        instr(1, 0, 0, 2, 0, 0, 1);
        tick();
        instr(1, 0, 0, 0, 0, 0, 0);
        #1;
        checks++;
        if (ready2 !== 1'b0 || stall2 !== 1'b1) begin
            errors++; $display("FAIL max_limit_block: ready %0b stall %0b expected 0 1", ready2, stall2);
        end
        checks++;
        if (decode_ready !== 1'b1) begin errors++; $display("FAIL max_limit_wide: got %0b expected 1", decode_ready); end
        tick();
        idle();
        checks++;
        if (infl2 !== 3'd2 || inflight_count !== 3'd2) begin
            errors++; $display("FAIL max_inflight_hold: got %0d/%0d expected 2/2", infl2, inflight_count);
        end
        $display("txn max limit: inflight %0d", infl2);
    endtask

    task automatic test_same_cycle();
        int e;
        do_reset();
        instr(1, 0, 0, 9, 0, 0, 1);
        exp_q.push_back(1);
        tick();
        e = exp_q.pop_front(); checks++;
        if (inflight_count !== 3'(e)) begin errors++; $display("FAIL same_issue9_sb: inflight %0d expected %0d", inflight_count, e); end
        else $display("txn issue rd9: inflight %0d", inflight_count);
        write = 1; write_reg = 9;
        exp_q.push_back(1);
        tick();
        idle();
        e = exp_q.pop_front(); checks++;
        if (inflight_count !== 3'(e)) begin errors++; $display("FAIL same_reg_sb: inflight %0d expected %0d", inflight_count, e); end
        else $display("txn issue+retire rd9: inflight %0d", inflight_count);
        instr(0, 9, 0, 0, 1, 0, 0);
        #1;
        checks++;
        if (rs1_pending !== 1'b1) begin errors++; $display("FAIL same_reg_count: pending %0b expected 1", rs1_pending); end
        idle();
        write = 1; write_reg = 9;
        exp_q.push_back(0);
        tick();
        write = 0;
        e = exp_q.pop_front(); checks++;
        if (inflight_count !== 3'(e)) begin errors++; $display("FAIL same_retire9_sb: inflight %0d expected %0d", inflight_count, e); end
        else $display("txn retire rd9: inflight %0d", inflight_count);
        instr(1, 0, 0, 3, 0, 0, 1);
        tick();
        instr(1, 0, 0, 4, 0, 0, 1);
        tick();
        instr(1, 0, 0, 3, 0, 0, 1);
        write = 1; write_reg = 4;
        exp_q.push_back(2);
        tick();
        idle();
        e = exp_q.pop_front(); checks++;
        if (inflight_count !== 3'(e)) begin errors++; $display("FAIL diff_reg_sb: inflight %0d expected %0d", inflight_count, e); end
        else $display("txn issue rd3+retire rd4: inflight %0d", inflight_count);
        instr(0, 4, 3, 0, 1, 1, 0);
        #1;
        checks++;
        if (rs1_pending !== 1'b0 || rs2_pending !== 1'b1) begin
            errors++; $display("FAIL diff_reg_counts: p4 %0b p3 %0b expected 0 1", rs1_pending, rs2_pending);
        end
        idle();
        write = 1; write_reg = 3;
        tick();
        write = 0;
        instr(0, 3, 0, 0, 1, 0, 0);
        #1;
        checks++;
        if (rs1_pending !== 1'b1 || inflight_count !== 3'd1) begin
            errors++; $display("FAIL diff_reg_count3: pending %0b inflight %0d expected 1 1", rs1_pending, inflight_count);
        end
        idle();
    endtask

    task automatic test_flush_drain();
        int e;
        do_reset();
        instr(1, 0, 0, 10, 0, 0, 1);
        tick();
        instr(1, 0, 0, 11, 0, 0, 1);
        tick();
        instr(1, 0, 0, 12, 0, 0, 1);
        flush = 1;
        #1;
        checks++;
        if (decode_ready !== 1'b0 || stall !== 1'b1) begin
            errors++; $display("FAIL flush_block: ready %0b stall %0b expected 0 1", decode_ready, stall);
        end
        exp_q.push_back(2);
        tick();
        flush = 0;
        e = exp_q.pop_front(); checks++;
        if (inflight_count !== 3'(e)) begin errors++; $display("FAIL flush_suppress_sb: inflight %0d expected %0d", inflight_count, e); end
        else $display("txn flush: inflight %0d", inflight_count);
        checks++;
        if (decode_ready !== 1'b0) begin errors++; $display("FAIL drain_ready: got %0b expected 0", decode_ready); end
        for (int i = 0; i < 2; i++) begin
            write = 1; write_reg = 5'(10 + i);
            exp_q.push_back(1 - i);
            tick();
            write = 0;
            e = exp_q.pop_front(); checks++;
            if (inflight_count !== 3'(e)) begin errors++; $display("FAIL drain_retire_sb_%0d: inflight %0d expected %0d", i, inflight_count, e); end
            else $display("txn drain retire: inflight %0d", inflight_count);
            checks++;
            if (decode_ready !== 1'b0) begin errors++; $display("FAIL drain_hold_%0d: ready %0b expected 0", i, decode_ready); end
        end
        tick();
        checks++;
        if (decode_ready !== 1'b1) begin errors++; $display("FAIL drain_exit: ready %0b expected 1", decode_ready); end
        $display("txn drain exit: ready %0b", decode_ready);
        idle();
    endtask

    task automatic test_underflow_reset();
        do_reset();
        write = 1; write_reg = 12;
        tick();
        write = 0;
        checks++;
        if (underflow_err !== 1'b1 || inflight_count !== 3'd0) begin
            errors++; $display("FAIL underflow_set: err %0b inflight %0d expected 1 0", underflow_err, inflight_count);
        end
        tick();
        checks++;
        if (underflow_err !== 1'b1) begin errors++; $display("FAIL underflow_sticky: got %0b expected 1", underflow_err); end
        for (int i = 1; i <= 3; i++) begin
            instr(1, 0, 0, 5'(i), 0, 0, 1);
            tick();
        end
        idle();
        flush = 1;
        tick();
        flush = 0;
        instr(1, 0, 0, 5, 0, 0, 1);
        #1;
        checks++;
        if (decode_ready !== 1'b0 || inflight_count !== 3'd3) begin
            errors++; $display("FAIL mid_drain: ready %0b inflight %0d expected 0 3", decode_ready, inflight_count);
        end
        reset = 1;
        #1;
        checks++;
        if (decode_ready !== 1'b0 || stall !== 1'b0) begin
            errors++; $display("FAIL drain_reset_cycle: ready %0b stall %0b expected 0 0", decode_ready, stall);
        end
        tick();
        reset = 0;
        #1;
        checks++;
        if (inflight_count !== 3'd0 || underflow_err !== 1'b0 || decode_ready !== 1'b1) begin
            errors++; $display("FAIL drain_reset_state: inflight %0d err %0b ready %0b expected 0 0 1",
                               inflight_count, underflow_err, decode_ready);
        end
        idle();
        write = 1; write_reg = 1;
        tick();
        write = 0;
        checks++;
        if (underflow_err !== 1'b1) begin errors++; $display("FAIL forgotten_retire: err %0b expected 1", underflow_err); end
        $display("txn reset mid-drain: err %0b", underflow_err);
    endtask

    task automatic test_back_to_back();
        int e;
        do_reset();
        for (int i = 0; i < 3; i++) begin
            instr(1, 0, 0, 5'(20 + i), 0, 0, 1);
            exp_q.push_back(i + 1);
            tick();
            e = exp_q.pop_front(); checks++;
            if (inflight_count !== 3'(e)) begin errors++; $display("FAIL b2b_issue_sb_%0d: inflight %0d expected %0d", i, inflight_count, e); end
            else $display("txn b2b issue rd%0d: inflight %0d", 20 + i, inflight_count);
        end
        instr(1, 0, 0, 23, 0, 0, 1);
        write = 1; write_reg = 20;
        exp_q.push_back(3);
        tick();
        idle();
        for (int i = 1; i < 4; i++) begin
            e = exp_q.pop_front(); checks++;
            if (inflight_count !== 3'(e)) begin errors++; $display("FAIL b2b_retire_sb_%0d: inflight %0d expected %0d", i, inflight_count, e); end
            else $display("txn b2b: inflight %0d", inflight_count);
            write = 1; write_reg = 5'(20 + i);
            exp_q.push_back(3 - i);
            tick();
            write = 0;
        end
        e = exp_q.pop_front(); checks++;
        if (inflight_count !== 3'(e)) begin errors++; $display("FAIL b2b_final_sb: inflight %0d expected %0d", inflight_count, e); end
        else $display("txn b2b drained: inflight %0d", inflight_count);
        checks++;
        if (underflow_err !== 1'b0) begin errors++; $display("FAIL b2b_err: got %0b expected 0", underflow_err); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        scan = 0;
        reset = 0;
        idle();
        test_reset();
        test_raw_hazard();
        test_x0();
        test_saturation();
        test_max_inflight();
        test_same_cycle();
        test_flush_drain();
        test_underflow_reset();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
